// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller.
// Holds the supported opcode constants, the controller state encoding
// and the encodings of the ALU operation and ALU B-operand selects.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LHU   = 6'h25;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_RD    = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WR    = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } alu_src_b_t;

  // True for every opcode that goes through the address-calculation step.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_LH) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the memory handshake states.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   incr        count one more wait cycle; when low the counter clears
//   at_limit    counter has reached WAIT_LIMIT
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic incr,
  output logic at_limit
);

  logic [CNT_W-1:0] count;

  assign at_limit = (count == CNT_W'(WAIT_LIMIT));

  // The counter only holds a value while the controller sits in a wait
  // state without mem_ready. Any other cycle (completion, leaving the
  // state, or the timeout cycle itself) clears it, so every entry into a
  // wait state starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (incr && !at_limit) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main controller for the MIPS core.
// Sequences the shared memory, ALU and register file through the
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps and waits on mem_ready
// with a bounded timeout.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   opcode                instruction[31:26] from the instruction register
//   mem_ready             memory finished the current access this cycle
//   pc_write..pc_source   datapath control strobes and selects
//   load_half/unsigned    halfword load writeback modifiers
//   illegal_op, bus_error one-cycle error pulses
//   state                 current state encoding for debug
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       load_half,
  output logic       load_unsigned,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state
);

  state_t cur_state;
  state_t next_state;
  logic   waiting;
  logic   at_limit;
  logic   timeout;

  assign waiting = (cur_state == FETCH) || (cur_state == MEM_RD) || (cur_state == MEM_WR);
  assign timeout = waiting && !mem_ready && at_limit;
  assign state   = cur_state;

  mem_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .incr     (waiting && !mem_ready),
    .at_limit (at_limit)
  );

  // State register. Reset forces IDLE, where every output is zero, so no
  // strobe survives the reset edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Next-state and output decode. Outputs depend on the state, with the
  // write/load strobes additionally qualified by mem_ready and the timeout
  // so that a timed-out access issues no memory request or strobe.
  always_comb begin
    next_state    = cur_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_ADD;
    pc_source     = 2'd0;
    load_half     = 1'b0;
    load_unsigned = 1'b0;
    illegal_op    = 1'b0;
    bus_error     = 1'b0;

    case (cur_state)
      IDLE: begin
        next_state = FETCH;
      end

      FETCH: begin
        mem_read  = !timeout;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = DECODE;
        end else if (timeout) begin
          bus_error  = 1'b1;
          next_state = FETCH;
        end
      end

      DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        if (opcode == OP_RTYPE) begin
          next_state = R_EXEC;
        end else if (opcode == OP_BEQ) begin
          next_state = BRANCH;
        end else if (opcode == OP_ADDI) begin
          next_state = ADDI_EXEC;
        end else if (is_mem_op(opcode)) begin
          next_state = MEM_ADDR;
        end else begin
          illegal_op = 1'b1;
          next_state = FETCH;
        end
      end

      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end

      MEM_RD: begin
        mem_read = !timeout;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          next_state = MEM_WB;
        end else if (timeout) begin
          bus_error  = 1'b1;
          next_state = FETCH;
        end
      end

      MEM_WB: begin
        reg_write     = 1'b1;
        mem_to_reg    = 1'b1;
        load_half     = (opcode == OP_LH) || (opcode == OP_LHU);
        load_unsigned = (opcode == OP_LHU);
        next_state    = FETCH;
      end

      MEM_WR: begin
        mem_write = !timeout;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          next_state = FETCH;
        end else if (timeout) begin
          bus_error  = 1'b1;
          next_state = FETCH;
        end
      end

      R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_FUNCT;
        next_state = R_WB;
      end

      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        next_state = FETCH;
      end

      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_RT;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        next_state    = FETCH;
      end

      ADDI_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = ADDI_WB;
      end

      ADDI_WB: begin
        reg_write  = 1'b1;
        next_state = FETCH;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       load_half;
  logic       load_unsigned;
  logic       illegal_op;
  logic       bus_error;
  logic [3:0] state;

  logic [19:0] allOut;
  int          checkCount = 0;
  int          passCount  = 0;

  assign allOut = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, load_half, load_unsigned, illegal_op, bus_error};

  multicycle_control #(
    .WAIT_LIMIT (15),
    .CNT_W      (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .load_half     (load_half),
    .load_unsigned (load_unsigned),
    .illegal_op    (illegal_op),
    .bus_error     (bus_error),
    .state         (state)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the inputs and let the combinational outputs settle.
  task automatic applyStimulus(input logic [5:0] op, input logic rdy);
    opcode    = op;
    mem_ready = rdy;
    #1;
  endtask

  // Advance one clock edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'h00;
    mem_ready = 1'b0;

    // Reset held for three cycles, then released between edges.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", state, 0);
    checkOutput("reset_outputs", allOut, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_state", state, 0);
    checkOutput("idle_outputs", allOut, 0);
    tick();
    checkOutput("fetch_state", state, 1);
    checkOutput("fetch_mem_read", mem_read, 1);
    checkOutput("fetch_no_ready_ir", ir_write, 0);

    // Zero-wait lw: 1,2,3,4,5,1.
    applyStimulus(OP_LW, 1'b1);
    checkOutput("lw_fetch_ir", ir_write, 1);
    checkOutput("lw_fetch_pc", pc_write, 1);
    checkOutput("lw_fetch_srcb", alu_src_b, 1);
    tick();
    checkOutput("lw_decode_state", state, 2);
    checkOutput("lw_decode_srcb", alu_src_b, 3);
    checkOutput("lw_decode_regw", reg_write, 0);
    tick();
    checkOutput("lw_addr_state", state, 3);
    checkOutput("lw_addr_srca", alu_src_a, 1);
    checkOutput("lw_addr_srcb", alu_src_b, 2);
    tick();
    checkOutput("lw_rd_state", state, 4);
    checkOutput("lw_rd_mem_read", mem_read, 1);
    checkOutput("lw_rd_iord", i_or_d, 1);
    checkOutput("lw_rd_regw", reg_write, 0);
    tick();
    checkOutput("lw_wb_state", state, 5);
    checkOutput("lw_wb_regw", reg_write, 1);
    checkOutput("lw_wb_memtoreg", mem_to_reg, 1);
    checkOutput("lw_wb_half", load_half, 0);
    tick();
    checkOutput("lw_done_state", state, 1);
    checkOutput("lw_done_regw", reg_write, 0);

    // lhu with mem_ready held off for three MEM_RD cycles.
    applyStimulus(OP_LHU, 1'b1);
    tick();
    checkOutput("lhu_decode_state", state, 2);
    tick();
    checkOutput("lhu_addr_state", state, 3);
    applyStimulus(OP_LHU, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("lhu_rd_wait_state", state, 4);
      checkOutput("lhu_rd_wait_read", mem_read, 1);
      tick();
    end
    applyStimulus(OP_LHU, 1'b1);
    checkOutput("lhu_rd_last_state", state, 4);
    tick();
    checkOutput("lhu_wb_state", state, 5);
    checkOutput("lhu_wb_half", load_half, 1);
    checkOutput("lhu_wb_unsigned", load_unsigned, 1);
    checkOutput("lhu_wb_regw", reg_write, 1);
    tick();
    checkOutput("lhu_done_state", state, 1);

    // Illegal opcode 0x3F.
    applyStimulus(6'h3F, 1'b1);
    tick();
    checkOutput("ill_decode_state", state, 2);
    checkOutput("ill_pulse", illegal_op, 1);
    checkOutput("ill_regw", reg_write, 0);
    checkOutput("ill_memw", mem_write, 0);
    tick();
    checkOutput("ill_next_state", state, 1);
    checkOutput("ill_pulse_gone", illegal_op, 0);

    // FETCH timeout: 15 wait cycles, then bus_error in the limit cycle.
    applyStimulus(OP_SW, 1'b0);
    for (int i = 0; i < 15; i++) begin
      checkOutput("to_wait_state", state, 1);
      checkOutput("to_wait_no_err", bus_error, 0);
      tick();
    end
    checkOutput("to_limit_err", bus_error, 1);
    checkOutput("to_limit_ir", ir_write, 0);
    checkOutput("to_limit_pc", pc_write, 0);
    tick();
    checkOutput("to_reenter_state", state, 1);
    checkOutput("to_reenter_no_err", bus_error, 0);

    // Second run: mem_ready arrives in the limit cycle.
    for (int i = 0; i < 15; i++) begin
      checkOutput("to2_wait_no_err", bus_error, 0);
      tick();
    end
    applyStimulus(OP_SW, 1'b1);
    checkOutput("to2_limit_no_err", bus_error, 0);
    checkOutput("to2_limit_ir", ir_write, 1);
    tick();
    checkOutput("sw_decode_state", state, 2);
    tick();
    checkOutput("sw_addr_state", state, 3);
    applyStimulus(OP_SW, 1'b0);
    tick();
    checkOutput("sw_wr_state", state, 6);
    checkOutput("sw_wr_memw", mem_write, 1);
    checkOutput("sw_wr_iord", i_or_d, 1);
    tick();
    checkOutput("sw_wr_hold_state", state, 6);

    // Reset dropped mid-write.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_memw", mem_write, 0);
    checkOutput("rst_mid_state", state, 0);
    checkOutput("rst_mid_outputs", allOut, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_rel_state", state, 0);
    tick();
    checkOutput("rst_resume_state", state, 1);
    checkOutput("rst_resume_read", mem_read, 1);

    // R-type: 1,2,7,8,1.
    applyStimulus(OP_RTYPE, 1'b1);
    tick();
    checkOutput("r_decode_state", state, 2);
    tick();
    checkOutput("r_exec_state", state, 7);
    checkOutput("r_exec_aluop", alu_op, 2);
    checkOutput("r_exec_srca", alu_src_a, 1);
    checkOutput("r_exec_srcb", alu_src_b, 0);
    tick();
    checkOutput("r_wb_state", state, 8);
    checkOutput("r_wb_regw", reg_write, 1);
    checkOutput("r_wb_regdst", reg_dst, 1);
    checkOutput("r_wb_memtoreg", mem_to_reg, 0);
    tick();
    checkOutput("r_done_state", state, 1);

    // beq: 1,2,9,1.
    applyStimulus(OP_BEQ, 1'b1);
    tick();
    checkOutput("beq_decode_state", state, 2);
    tick();
    checkOutput("beq_state", state, 9);
    checkOutput("beq_cond", pc_write_cond, 1);
    checkOutput("beq_pcsrc", pc_source, 1);
    checkOutput("beq_aluop", alu_op, 1);
    checkOutput("beq_pcw", pc_write, 0);
    tick();
    checkOutput("beq_done_state", state, 1);

    // addi: 1,2,10,11,1.
    applyStimulus(OP_ADDI, 1'b1);
    tick();
    checkOutput("addi_decode_state", state, 2);
    tick();
    checkOutput("addi_exec_state", state, 10);
    checkOutput("addi_exec_srcb", alu_src_b, 2);
    tick();
    checkOutput("addi_wb_state", state, 11);
    checkOutput("addi_wb_regw", reg_write, 1);
    checkOutput("addi_wb_regdst", reg_dst, 0);
    tick();
    checkOutput("addi_done_state", state, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main controller for the MIPS core. It replaces the single-cycle opcode decoder and sequences one shared memory, ALU and register file through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps.
- It supports the opcodes 0x00 (R-type), 0x04 (beq), 0x08 (addi), 0x23 (lw), 0x2B (sw), 0x21 (lh) and 0x25 (lhu).
- It waits on a memory ready handshake, bounded by a timeout.

Parameters:
- WAIT_LIMIT, 15: maximum cycles spent waiting for mem_ready in one memory state before a bus error.
- CNT_W, 4: width of the wait counter. It must hold WAIT_LIMIT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction[31:26] from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory completed the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load instruction register.
- mem_to_reg  out  1  writeback data select: 1=MDR.
- reg_dst  out  1  destination select: 1=rd, 0=rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0=PC, 1=rs.
- alu_src_b  out  2  0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- alu_op  out  2  0=add, 1=sub, 2=funct-decoded.
- pc_source  out  2  0=ALU result, 1=ALUOut.
- load_half  out  1  writeback is a halfword load (lh/lhu).
- load_unsigned  out  1  zero-extend halfword (lhu).
- illegal_op  out  1  one-cycle pulse: unsupported opcode.
- bus_error  out  1  one-cycle pulse: mem_ready timeout.
- state  out  4  current state encoding, for debug.

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, ADDI_EXEC=10, ADDI_WB=11.
- Reset: state=IDLE and wait counter=0. All outputs are 0 while in IDLE. IDLE always advances to FETCH on the next cycle.
- Reset asserted mid-instruction returns to IDLE immediately. No partial pc_write, reg_write or mem_write is issued after the reset edge.
- Outputs are combinational from state. ir_write, pc_write (FETCH only), reg_write (MEM_WB) and mem_write remain qualified as listed below.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; that cycle transitions to DECODE.
  - Otherwise the block stays in FETCH.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute).
  - Next state by opcode: 0x00->R_EXEC; 0x04->BRANCH; 0x08->ADDI_EXEC; 0x23/0x21/0x25/0x2B->MEM_ADDR.
  - Any other opcode pulses illegal_op for this cycle and goes to FETCH.
- MEM_ADDR: drives alu_src_a=1, alu_src_b=2, alu_op=0. Next state is MEM_WR for 0x2B, else MEM_RD.
- MEM_RD: drives mem_read=1, i_or_d=1. Advances to MEM_WB when mem_ready=1.
- MEM_WB:
  - Drives reg_write=1, mem_to_reg=1, reg_dst=0.
  - load_half=1 for 0x21/0x25; load_unsigned=1 for 0x25 only.
  - Next state is FETCH.
- MEM_WR: drives mem_write=1, i_or_d=1 while waiting. Goes to FETCH when mem_ready=1.
- R_EXEC: drives alu_src_a=1, alu_src_b=0, alu_op=2. Next state is R_WB.
- R_WB: drives reg_write=1, reg_dst=1, mem_to_reg=0. Next state is FETCH.
- BRANCH: drives alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1. Next state is FETCH.
- ADDI_EXEC: drives alu_src_a=1, alu_src_b=2, alu_op=0. Next state is ADDI_WB.
- ADDI_WB: drives reg_write=1, reg_dst=0, mem_to_reg=0. Next state is FETCH.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle in one of those states with mem_ready=0.
  - If it reaches WAIT_LIMIT with mem_ready still 0: bus_error pulses for that cycle, no strobes are issued, and next state is FETCH.
  - mem_ready=1 in the limit cycle wins: normal completion, no bus_error.
- Latency with zero-wait memory (mem_ready tied 1): beq 3 cycles; R-type, addi and sw 4 cycles; lw, lh and lhu 5 cycles.
- opcode is sampled only in DECODE, MEM_ADDR and MEM_WB. It must stay stable from the ir_write cycle to the end of the instruction.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - Opcode constants: OP_RTYPE, OP_BEQ, OP_ADDI, OP_LW, OP_SW, OP_LH, OP_LHU.
  - State enum with the encodings above.
  - alu_op and alu_src_b encodings.
- One sub-module, mem_wait_timer: counter, clear, increment and limit flag, parameterised by WAIT_LIMIT and CNT_W.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then release -> all outputs 0 and state=0; state=1 on the next edge with mem_read=1.
- Zero-wait lw (opcode 0x23, mem_ready=1) -> states 1,2,3,4,5,1; reg_write=1 and mem_to_reg=1 only in state 5; load_half=0.
- lhu with mem_ready delayed 3 cycles in MEM_RD -> 3 extra cycles in state 4; then state 5 with load_half=1 and load_unsigned=1.
- Illegal opcode 0x3F -> illegal_op pulses once in DECODE; next state is FETCH; no reg_write or mem_write occurs.
- FETCH timeout with mem_ready=0 and WAIT_LIMIT=15 -> bus_error pulses exactly once after 15 wait cycles, with no ir_write; re-enters FETCH with the counter cleared. A second run asserts mem_ready in the limit cycle -> no bus_error.
- rst_n dropped during MEM_WR (sw, mem_ready=0) -> mem_write deasserts immediately; state=IDLE; normal fetch resumes after release.
